// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin arbiter in front of one shared WIDTH-bit register
// Optional feature macro: ARB_LOCK_EN (adds lock input and sticky ownership)
module reg_share_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   wdata,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]         lock,
`endif
  output logic [N-1:0]         gnt,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qb,
  output logic                 wr_vld,
  output logic [IDXW-1:0]      wr_src
);

  logic [IDXW-1:0] last;
  logic [IDXW-1:0] rr_idx;
  logic            rr_any;
  logic [IDXW-1:0] sel_idx;
  logic            sel_any;

  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IDXW'(s);
  endfunction

  // Search last+1 .. last+N; the first requester found wins, so last itself is checked last.
  always_comb begin
    rr_any = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= N; k++) begin
      if (!rr_any && req[wrap_idx(last, k)]) begin
        rr_any = 1'b1;
        rr_idx = wrap_idx(last, k);
      end
    end
  end

`ifdef ARB_LOCK_EN
  logic            lock_own;
  logic [IDXW-1:0] owner;
  logic            lock_hold;

  // An owner that drops req keeps everyone else out for that cycle; dropping lock hands back to round-robin.
  assign lock_hold = lock_own && lock[owner];

  always_comb begin
    if (lock_hold) begin
      sel_any = req[owner];
      sel_idx = owner;
    end else begin
      sel_any = rr_any;
      sel_idx = rr_idx;
    end
  end
`else
  assign sel_any = rr_any;
  assign sel_idx = rr_idx;
`endif

  always_comb begin
    gnt = '0;
    if (rst_n && sel_any) gnt[sel_idx] = 1'b1;
  end

  assign qb = ~q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      last   <= IDXW'(N - 1);
      wr_src <= '0;
      wr_vld <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_own <= 1'b0;
      owner    <= '0;
`endif
    end else begin
      wr_vld <= sel_any;
      if (sel_any) begin
        q      <= wdata[int'(sel_idx)*WIDTH +: WIDTH];
        last   <= sel_idx;
        wr_src <= sel_idx;
      end
`ifdef ARB_LOCK_EN
      if (lock_own && (!req[owner] || !lock[owner])) lock_own <= 1'b0;
      if (sel_any && lock[sel_idx]) begin
        lock_own <= 1'b1;
        owner    <= sel_idx;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - table-driven bench with write scoreboard for reg_share_arb
module tb_reg_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  lock;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qb;
  logic        wr_vld;
  logic [1:0]  wr_src;

  reg_share_arb #(.N(4), .WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .q      (q),
    .qb     (qb),
    .wr_vld (wr_vld),
    .wr_src (wr_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  exp_gnt;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] src;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  sb_t  mon_e;
  logic [7:0] mon_qb;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic void add(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g);
    vec_t v;
    v.req = r; v.wdata = d; v.exp_gnt = g;
    vecs.push_back(v);
  endfunction

  task automatic push_exp(input logic [3:0] g, input logic [31:0] d);
    sb_t e;
    e.src = 2'(oh2idx(g));
    e.d   = d[oh2idx(g)*8 +: 8];
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_vld === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_write: got wr_vld 1 expected no pending write at %0t", $time);
      end else begin
        mon_e  = sbq.pop_front();
        mon_qb = ~mon_e.d;
        chk("sb_q", q, mon_e.d);
        chk("sb_qb", qb, mon_qb);
        chk("sb_wr_src", wr_src, mon_e.src);
      end
    end
  end

  initial begin
    logic [7:0] cur_q;
    logic [7:0] exp_qb;
    logic [3:0] prev_g;

    // round robin from reset, then wrap/skip, single write, idle hold, single requester
    for (int k = 0; k < 8; k++) add(4'b1111, 32'h13121110, 4'(1 << (k % 4)));
    add(4'b1010, 32'h44332211, 4'b0010);
    add(4'b1010, 32'h44332211, 4'b1000);
    add(4'b1010, 32'h44332211, 4'b0010);
    add(4'b0100, 32'h00A50000, 4'b0100);
    add(4'b0000, 32'h00000000, 4'b0000);
    add(4'b1000, 32'h3C000000, 4'b1000);
    for (int k = 0; k < 5; k++) add(4'b0000, 32'h00000000, 4'b0000);
    for (int k = 0; k < 3; k++) add(4'b0010, 32'h00005500, 4'b0010);
    add(4'b0000, 32'h00000000, 4'b0000);

    rst_n = 1'b0; req = 4'b1111; wdata = 32'h13121110; lock = 4'b0000;
    #3;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_q", q, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_wr_vld", wr_vld, 1'b0);
    chk("rst_wr_src", wr_src, 2'd0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    cur_q = 8'h00;
    prev_g = 4'b0000;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      req   = vecs[i].req;
      wdata = vecs[i].wdata;
      if (vecs[i].exp_gnt != 4'b0000) push_exp(vecs[i].exp_gnt, vecs[i].wdata);
      @(negedge clk);
      exp_qb = ~cur_q;
      chk($sformatf("v%0d_gnt", i), gnt, vecs[i].exp_gnt);
      chk($sformatf("v%0d_q", i), q, cur_q);
      chk($sformatf("v%0d_qb", i), qb, exp_qb);
      chk($sformatf("v%0d_wr_vld", i), wr_vld, (prev_g != 4'b0000));
      if (vecs[i].exp_gnt != 4'b0000) cur_q = vecs[i].wdata[oh2idx(vecs[i].exp_gnt)*8 +: 8];
      prev_g = vecs[i].exp_gnt;
    end

    // asynchronous reset mid-cycle with all requests pending
    @(posedge clk);
    #1;
    req = 4'b1111; wdata = 32'h13121110;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 4'b0000);
    chk("arst_q", q, 8'h00);
    chk("arst_qb", qb, 8'hFF);
    chk("arst_wr_vld", wr_vld, 1'b0);
    chk("arst_wr_src", wr_src, 2'd0);
    @(posedge clk);
    @(negedge clk);
    chk("arst_hold_q", q, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", gnt, 4'b0001);
    push_exp(4'b0001, wdata);
    @(posedge clk);
    #1;
    req = 4'b0000;
    @(negedge clk);
    chk("post_rst_q", q, 8'h10);
    @(negedge clk);
    chk("post_rst_wr_vld_low", wr_vld, 1'b0);

`ifdef ARB_LOCK_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      req = 4'b0011; wdata = 32'h00002211; lock = 4'b0001;
      push_exp(4'b0001, wdata);
      @(negedge clk);
      chk($sformatf("lock%0d_gnt", k), gnt, 4'b0001);
    end
    @(posedge clk);
    #1;
    lock = 4'b0000;
    push_exp(4'b0010, wdata);
    @(negedge clk);
    chk("unlock_gnt", gnt, 4'b0010);
    @(posedge clk);
    #1;
    req = 4'b0000;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_share_arb.md
Name: reg_share_arb

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-type storage register among N requesters.
- Each cycle it grants at most one writer, captures that writer's data into the register, and presents q and qb = ~q to all consumers.
- Sits between several producer blocks and one shared state/flag register, replacing ad-hoc muxing in front of a plain dff.

Parameters:
- N, 4, number of requesters (2..16)
- WIDTH, 8, data/register width in bits
- IDXW, $clog2(N), width of requester index outputs (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-requester write request, level-sensitive
- wdata  input  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- gnt  output  N  one-hot grant, combinational from req and pointer; zero when req==0
- q  output  WIDTH  shared register contents
- qb  output  WIDTH  bitwise inverse of q, combinational
- wr_vld  output  1  registered; high for one cycle after each register write
- wr_src  output  IDXW  registered index of the requester that performed the last write
- lock  input  N  present only with ARB_LOCK_EN (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: q=0, qb=all ones, wr_vld=0, wr_src=0, last-grant pointer = N-1 (requester 0 has top priority after reset).
- Arbitration: search order is last+1, last+2, … wrapping modulo N; the first asserted req wins. gnt is valid in the same cycle as req (zero-latency grant).
- Write: at the posedge where gnt[i]=1, q <= wdata slice i, last <= i, wr_src <= i, wr_vld <= 1.
- Write latency: q shows the new value one cycle after the grant cycle.
- Idle: req==0 → gnt=0; q, last and wr_src hold; wr_vld <= 0.
- Requester rules: keep req and wdata stable until gnt is seen; deassert or present the next data the cycle after gnt. Same-value rewrites are legal and still pulse wr_vld.
- Single requester: continuously asserted, it wins every cycle (pointer wraps back to itself).
- Pointer wrap: from last=N-1, the search starts at 0.
- Reset mid-operation: rst_n low asynchronously forces all reset values immediately; gnt falls to 0 while rst_n is low, regardless of req. The first cycle after release uses last=N-1.
- Invariants: gnt is always one-hot or zero; no combinational path from wdata to gnt.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds the lock[N-1:0] input and a lock_own state bit plus owner index (reset: lock_own=0).
  - If the granted requester i has lock[i]=1 at its grant edge, lock_own<=1 and owner<=i.
  - While lock_own=1, gnt is forced to owner whenever req[owner]=1; all other requests are ignored and the pointer is not advanced. If req[owner]=0, gnt=0 and no write occurs.
  - Ownership ends at the first edge where req[owner]=0 or lock[owner]=0; normal round-robin resumes from last=owner in that same cycle.
- Undefined: no lock port, no lock state; pure round-robin only.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req=4'b1111 → q=8'h00, qb=8'hFF, gnt=0, wr_vld=0 immediately.
- Single write: req=4'b0100, wdata[23:16]=8'hA5 for one cycle → gnt=4'b0100; next cycle q=8'hA5, qb=8'h5A, wr_vld=1, wr_src=2; following cycle wr_vld=0.
- Round-robin fairness: req=4'b1111 held for 8 cycles after reset, data i=8'h10+i → grant order 0,1,2,3,0,1,2,3; q sequence 10,11,12,13,10,…
- Wrap and skip: last=3, req=4'b1010 → grant 1, then 3, then 1; requesters 0 and 2 are never granted.
- Idle hold: after a write of 8'h3C, req=0 for 5 cycles → q stays 8'h3C, gnt=0, wr_vld=0.
- ARB_LOCK_EN: req=4'b0011, lock=4'b0001 for 4 cycles → gnt=4'b0001 all 4 cycles; drop lock[0] → requester 1 is granted next cycle.
